// File: rtl/dmem_access_ctrl.sv
// Multi-cycle data-memory access controller: turns single-cycle MemRead/MemWrite into issue/wait/response with pipeline stall.
// Optional macro ALIGN_CHECK_EN rejects odd addresses with an err pulse instead of issuing an access.
module dmem_access_ctrl #(
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_wr;
    logic [15:0]        r_mem_addr;
    logic [15:0]        r_mem_wdata;
    logic [15:0]        r_rdata;
    logic               w_accept;
    logic               w_req_err;

    // Handshake: a request is taken only in IDLE; stall stays high from that cycle
    // until RESP, where done pulses and the pipeline advances at the end of the cycle.
`ifdef ALIGN_CHECK_EN
    assign w_accept  = (req_rd ^ req_wr) & ~addr[0];
    assign w_req_err = (req_rd & req_wr) | ((req_rd | req_wr) & addr[0]);
`else
    assign w_accept  = req_rd ^ req_wr;
    assign w_req_err = req_rd & req_wr;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall  = 1'b1;
                    w_next = S_ISSUE;
                end else if (w_req_err) begin
                    err = 1'b1;
                end
            end
            S_ISSUE: begin
                stall  = 1'b1;
                mem_rd = ~r_is_wr;
                mem_wr = r_is_wr;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_wr     <= req_wr;
                        r_mem_addr  <= addr;
                        r_mem_wdata <= wdata;
                    end
                end
                S_ISSUE: r_cnt <= CNT_W'(MEM_LAT);
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Read data is valid exactly in the last wait cycle.
                    if (r_cnt == CNT_W'(1) && !r_is_wr) begin
                        r_rdata <= mem_rdata;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: two instances (latency 4 and 1), a fixed-latency memory responder
// and a transaction-level reference model of stall/strobe/done timing and read data.
module tb_dmem_access_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_rd    [2];
    logic        req_wr    [2];
    logic [15:0] addr      [2];
    logic [15:0] wdata     [2];
    logic [15:0] mem_rdata [2];
    logic        stall     [2];
    logic        done      [2];
    logic        err       [2];
    logic        mem_rd    [2];
    logic        mem_wr    [2];
    logic [15:0] rdata     [2];
    logic [15:0] mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [1:0]  dbg_state [2];

    int vecs = 0;
    int miscmp = 0;

    logic [15:0] ref_mem   [2][256];
    bit          ref_v     [2][256];
    logic [15:0] exp_rdata [2];

    dmem_access_ctrl #(.MEM_LAT(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .req_rd(req_rd[0]), .req_wr(req_wr[0]),
        .addr(addr[0]), .wdata(wdata[0]), .stall(stall[0]), .done(done[0]),
        .rdata(rdata[0]), .err(err[0]), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .dbg_state(dbg_state[0])
    );

    dmem_access_ctrl #(.MEM_LAT(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .req_rd(req_rd[1]), .req_wr(req_wr[1]),
        .addr(addr[1]), .wdata(wdata[1]), .stall(stall[1]), .done(done[1]),
        .rdata(rdata[1]), .err(err[1]), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .dbg_state(dbg_state[1])
    );

    function automatic int lat(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    // Power-up memory contents; 0x0010 holds 0xBEEF.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a[7:0] == 8'h10) return 16'hBEEF;
        return {a[7:0], a[7:0]} ^ 16'hC35A;
    endfunction

    function automatic logic [15:0] ref_read(input int u, input logic [15:0] a);
        if (ref_v[u][a[7:0]]) return ref_mem[u][a[7:0]];
        return init_val(a);
    endfunction

    function automatic logic [4:0] flags(input int u);
        return {stall[u], done[u], err[u], mem_rd[u], mem_wr[u]};
    endfunction

    // Memory responder: read data is valid only in the cycle MEM_LAT cycles after the strobe.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        localparam int L = (g == 0) ? 4 : 1;
        int          cd;
        logic [15:0] rd_a;
        logic [15:0] mem_q [256];
        bit          wr_v  [256];
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                cd <= 0;
            end else begin
                if (mem_rd[g]) begin
                    cd   <= L;
                    rd_a <= mem_addr[g];
                end else if (cd > 0) begin
                    cd <= cd - 1;
                end
                if (mem_wr[g]) begin
                    mem_q[mem_addr[g][7:0]] <= mem_wdata[g];
                    wr_v[mem_addr[g][7:0]]  <= 1'b1;
                end
            end
        end
        assign mem_rdata[g] = (cd == 1) ? (wr_v[rd_a[7:0]] ? mem_q[rd_a[7:0]] : init_val(rd_a))
                                        : 16'hDEAD;
    end

    task automatic do_idle(input int u, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            req_rd[u] = 1'b0; req_wr[u] = 1'b0;
            @(negedge clk);
            if (flags(u) !== 5'b0) begin
                $display("FAIL idle u%0d: flags=%b expected=%b", u, flags(u), 5'b0);
                miscmp++;
            end
            vecs++;
        end
    endtask

    task automatic do_access(input int u, input bit is_wr, input logic [15:0] a, input logic [15:0] d);
        int n;
        logic [4:0] exp_f;
        n = lat(u);
        if (is_wr) begin
            ref_mem[u][a[7:0]] = d;
            ref_v[u][a[7:0]] = 1'b1;
        end else begin
            exp_rdata[u] = ref_read(u, a);
        end
        @(posedge clk); #1;
        req_rd[u] = ~is_wr; req_wr[u] = is_wr; addr[u] = a; wdata[u] = d;
        for (int k = 0; k <= n + 2; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                req_rd[u] = 1'($urandom_range(0, 1));
                req_wr[u] = 1'($urandom_range(0, 1));
                addr[u] = 16'($urandom);
                wdata[u] = 16'($urandom);
            end
            @(negedge clk);
            exp_f = {(k <= n + 1), (k == n + 2), 1'b0, (k == 1 && !is_wr), (k == 1 && is_wr)};
            if (flags(u) !== exp_f) begin
                $display("FAIL access u%0d a=%h cyc%0d: flags=%b expected=%b", u, a, k, flags(u), exp_f);
                miscmp++;
            end
            vecs++;
            if (k == 1) begin
                if (mem_addr[u] !== a || (is_wr && mem_wdata[u] !== d)) begin
                    $display("FAIL strobe u%0d: addr=%h wdata=%h expected addr=%h wdata=%h",
                             u, mem_addr[u], mem_wdata[u], a, d);
                    miscmp++;
                end
                vecs++;
            end
            if (k == n + 2) begin
                if (rdata[u] !== exp_rdata[u]) begin
                    $display("FAIL rdata u%0d a=%h: got=%h expected=%h", u, a, rdata[u], exp_rdata[u]);
                    miscmp++;
                end
                vecs++;
            end
        end
        req_rd[u] = 1'b0; req_wr[u] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_rd[u] = 1'b0; req_wr[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
            exp_rdata[u] = '0;
        end
        #2;
        for (int u = 0; u < 2; u++) begin
            if ({flags(u), rdata[u], mem_addr[u], mem_wdata[u]} !== 53'b0) begin
                $display("FAIL reset u%0d: flags=%b rdata=%h mem_addr=%h mem_wdata=%h expected all zero",
                         u, flags(u), rdata[u], mem_addr[u], mem_wdata[u]);
                miscmp++;
            end
            vecs++;
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        do_idle(0, 2);
        do_idle(1, 1);
    endtask

    task automatic test_reset_mid_access;
        @(posedge clk); #1;
        req_rd[0] = 1'b1; addr[0] = 16'h0040;
        @(posedge clk); #1;
        req_rd[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        if (flags(0) !== 5'b0 || rdata[0] !== 16'h0) begin
            $display("FAIL reset_mid: flags=%b rdata=%h expected flags=%b rdata=0000", flags(0), rdata[0], 5'b0);
            miscmp++;
        end
        vecs++;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        @(negedge clk);
        rst = 1'b1;
        do_idle(0, 6);
        do_idle(1, 2);
    endtask

    task automatic test_read;
        do_access(0, 1'b0, 16'h0010, 16'h0000);
        if (exp_rdata[0] !== 16'hBEEF || rdata[0] !== 16'hBEEF) begin
            $display("FAIL read_beef: got=%h expected=%h", rdata[0], 16'hBEEF);
            miscmp++;
        end
        vecs++;
        do_idle(0, 2);
    endtask

    task automatic test_write;
        do_access(0, 1'b1, 16'h0020, 16'h1234);
        do_idle(0, 1);
        do_access(0, 1'b0, 16'h0020, 16'h0000);
        do_idle(0, 1);
    endtask

    task automatic test_back_to_back;
        do_access(1, 1'b0, 16'h0002, 16'h0000);
        do_access(1, 1'b0, 16'h0004, 16'h0000);
        do_access(1, 1'b1, 16'h0004, 16'hA5A5);
        do_access(1, 1'b0, 16'h0004, 16'h0000);
        do_idle(1, 2);
        do_access(0, 1'b1, 16'h0030, 16'h7E57);
        do_access(0, 1'b0, 16'h0030, 16'h0000);
        do_idle(0, 2);
    endtask

    task automatic test_err;
        for (int u = 0; u < 2; u++) begin
            @(posedge clk); #1;
            req_rd[u] = 1'b1; req_wr[u] = 1'b1; addr[u] = 16'h0008;
            @(negedge clk);
            if (flags(u) !== 5'b00100) begin
                $display("FAIL err_both u%0d: flags=%b expected=%b", u, flags(u), 5'b00100);
                miscmp++;
            end
            vecs++;
            do_idle(u, 3);
        end
    endtask

    task automatic test_align;
`ifdef ALIGN_CHECK_EN
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            req_rd[0] = 1'b1; req_wr[0] = (j == 1); addr[0] = 16'h0003;
            @(negedge clk);
            if (flags(0) !== 5'b00100) begin
                $display("FAIL align case%0d: flags=%b expected=%b", j, flags(0), 5'b00100);
                miscmp++;
            end
            vecs++;
            do_idle(0, 2);
        end
`else
        do_access(0, 1'b0, 16'h0003, 16'h0000);
        do_idle(0, 1);
`endif
    endtask

    task automatic test_random;
        int u;
        logic [15:0] a;
        for (int i = 0; i < 40; i++) begin
            u = $urandom_range(0, 1);
            a = 16'($urandom_range(0, 31) * 2);
            do_access(u, 1'($urandom_range(0, 1)), a, 16'($urandom));
            do_idle(u, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_err();
        test_align();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Multi-cycle data-memory access controller between the EX/MEM pipeline register and a fixed-latency data memory. It converts single-cycle MemRead/MemWrite requests into a request/wait/response sequence. It asserts a stall to the pipeline until the access completes, then returns read data to the MEM/WB path. It replaces the single-cycle memory interface, so the pipeline can run against slower, banked memory.

Parameters:
MEM_LAT, 4, memory latency in cycles from the mem_rd/mem_wr pulse to valid mem_rdata or write completion; legal range 1..(2**CNT_W - 1).
CNT_W, 3, width of the internal latency counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
req_rd  in  1  read request from EX/MEM (MemRead).
req_wr  in  1  write request from EX/MEM (MemWrite).
addr  in  16  access address (ALU result).
wdata  in  16  store data (read2 from EX/MEM).
stall  out  1  holds IF/ID, ID/EX and EX/MEM while high.
done  out  1  one-cycle pulse: the access completed this cycle.
rdata  out  16  registered read data, valid while done is high.
err  out  1  one-cycle pulse on an illegal request; ORed into proc err.
mem_rd  out  1  one-cycle read strobe to memory.
mem_wr  out  1  one-cycle write strobe to memory.
mem_addr  out  16  latched address to memory.
mem_wdata  out  16  latched write data to memory.
mem_rdata  in  16  memory read data, valid MEM_LAT cycles after mem_rd.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; cnt=0; stall, done, err, mem_rd, mem_wr = 0; rdata, mem_addr, mem_wdata = 0. Mid-access reset aborts immediately, with no completion pulse.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_rd XOR req_wr: latch addr, wdata and type. Next state is ISSUE. stall=1 combinationally in this cycle.
  - req_rd AND req_wr: err=1 for this cycle. No access. Stay IDLE. stall=0.
  - No request: stall=0.
- ISSUE (cycle t): mem_rd or mem_wr=1 per the latched type; mem_addr/mem_wdata driven from the latches. Load cnt=MEM_LAT. Go to WAIT. stall=1.
- WAIT (cycles t+1..t+MEM_LAT): stall=1, strobes=0.
  - cnt decrements each cycle.
  - When cnt==1: for reads, capture mem_rdata into rdata; go to RESP.
- RESP (cycle t+MEM_LAT+1): done=1, stall=0. The pipeline advances at the end of this cycle.
  - Next state is always IDLE. Request inputs in RESP belong to the completing instruction and are ignored.
- Writes: rdata holds its previous value.
- Total stall cycles per access: MEM_LAT+2.
- Request inputs may change while stall=1; only the values latched in IDLE are used.
- mem_addr/mem_wdata hold their last latched values between accesses.
- At most one outstanding access; strobes are never high in two consecutive cycles.

Optional Feature:
ALIGN_CHECK_EN:
- Defined: a request in IDLE with addr[0]=1 produces err=1 for one cycle, no strobe and stall=0, and the state stays IDLE. The alignment check takes precedence over the req_rd AND req_wr error; both conditions produce a single err pulse.
- Undefined: addr is passed unchanged and odd addresses are accessed normally.

Test Plan:
1. Reset: rst=0 then released. All outputs are 0 and the state is IDLE. Drive rst=0 during a WAIT → strobes and stall drop immediately.
2. Read, MEM_LAT=4: addr=0x0010, memory returns 0xBEEF → mem_rd pulses one cycle after the request. stall is high for 6 cycles. done=1 with rdata=0xBEEF in the 7th cycle.
3. Write, MEM_LAT=4: addr=0x0020, wdata=0x1234 → one mem_wr pulse with mem_addr=0x0020 and mem_wdata=0x1234. done after 6 stall cycles. rdata unchanged.
4. MEM_LAT=1, back-to-back reads to 0x0002 and 0x0004 → each read stalls 3 cycles, with exactly one IDLE cycle between accesses. Each rdata is correct.
5. req_rd=req_wr=1 → err pulses for one cycle; no strobe, stall=0.
6. With ALIGN_CHECK_EN defined, read addr=0x0003 → err=1, no mem_rd, no stall. With it undefined, a normal read of 0x0003.
